k007232_pcm: RTL and testbench

// - Two-channel 7-bit PCM playback engine (Konami 007232 style) between the sound CPU and sample ROM.
// - CPU writes 14 registers: per-channel pitch, prescaler, start address, key-on; plus loop flags and an external strobe.
// - Channels A and B time-share one 17-bit ROM address bus and emit unsigned 7-bit samples on ASD/BSD.

---
 rtl/k007232_pkg.sv | 39 +++
 rtl/k007232_channel.sv | 84 ++++++++
 rtl/k007232_pcm.sv | 121 ++++++++++++
 tb/tb_k007232_pcm.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/k007232_pkg.sv
// Shared widths, register map and prescaler encoding for the 007232 PCM engine.
package k007232_pkg;

    localparam int unsigned SA_W     = 17;
    localparam int unsigned PITCH_W  = 12;
    localparam int unsigned SAMPLE_W = 7;

    // Per-channel offsets; channel B sits REG_CH_B above channel A.
    localparam logic [3:0] REG_PITCH_L = 4'd0;
    localparam logic [3:0] REG_PITCH_H = 4'd1;
    localparam logic [3:0] REG_START_L = 4'd2;
    localparam logic [3:0] REG_START_M = 4'd3;
    localparam logic [3:0] REG_START_H = 4'd4;
    localparam logic [3:0] REG_KEYON   = 4'd5;
    localparam logic [3:0] REG_CH_B    = 4'd6;
    localparam logic [3:0] REG_SOEV    = 4'd12;
    localparam logic [3:0] REG_LOOP    = 4'd13;

    typedef enum logic [1:0] {
        PRESC_12  = 2'b00,
        PRESC_8   = 2'b01,
        PRESC_4   = 2'b10,
        PRESC_12X = 2'b11
    } presc_t;

    typedef enum logic {
        PH_A = 1'b0,
        PH_B = 1'b1
    } phase_t;

    function automatic logic [PITCH_W-1:0] presc_mask(input presc_t p);
        case (p)
            PRESC_8: return 12'h0FF;
            PRESC_4: return 12'h00F;
            default: return 12'hFFF;
        endcase
    endfunction

endpackage

// File: rtl/k007232_channel.sv
// One PCM voice: pitch/start registers, pitch counter, ROM address and sample latch.
module k007232_channel
    import k007232_pkg::*;
(
    input  logic                clk,
    input  logic                res,
    input  logic                wr_en,
    input  logic [3:0]          wr_sel,
    input  logic [7:0]          wr_data,
    input  logic                keyon,
    input  logic                loop_en,
    input  logic                tick,
    input  logic [7:0]          ram,
    output logic [SA_W-1:0]     addr,
    output logic [SAMPLE_W-1:0] sample
);

    logic [PITCH_W-1:0] pitch;
    logic [PITCH_W-1:0] cnt;
    logic [PITCH_W-1:0] mask;
    logic [PITCH_W-1:0] cnt_step;
    logic [SA_W-1:0]    start;
    presc_t             presc;
    logic               playing;
    logic               ovf;

    // Only the bits inside the prescaler width count; bits above it hold.
    always_comb begin
        mask     = presc_mask(presc);
        ovf      = ((cnt & mask) == mask);
        cnt_step = (cnt & ~mask) | ((cnt + PITCH_W'(1)) & mask);
    end

    always_ff @(posedge clk) begin
        if (res) begin
            pitch   <= '0;
            presc   <= PRESC_12;
            start   <= '0;
            cnt     <= '0;
            addr    <= '0;
            sample  <= '0;
            playing <= 1'b0;
        end else begin
            if (wr_en) begin
                case (wr_sel)
                    REG_PITCH_L: pitch[7:0]  <= wr_data;
                    REG_PITCH_H: begin
                        pitch[11:8] <= wr_data[3:0];
                        presc       <= presc_t'(wr_data[5:4]);
                    end
                    REG_START_L: start[7:0]  <= wr_data;
                    REG_START_M: start[15:8] <= wr_data;
                    REG_START_H: start[16]   <= wr_data[0];
                    default: ;
                endcase
            end

            // Key-on takes priority over whatever the current tick would do.
            if (keyon) begin
                addr    <= start;
                cnt     <= pitch;
                playing <= 1'b1;
            end else if (tick && playing) begin
                if (ram[7]) begin
                    if (loop_en) begin
                        addr <= start;
                        cnt  <= pitch;
                    end else begin
                        playing <= 1'b0;
                    end
                end else begin
                    sample <= ram[SAMPLE_W-1:0];
                    if (ovf) begin
                        cnt  <= pitch;
                        addr <= addr + SA_W'(1);
                    end else begin
                        cnt  <= cnt_step;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/k007232_pcm.sv
// Two-channel 007232-style PCM engine: CPU register decode, A/B phase ROM sharing, DB readback.
// Define K007232_READ_KEYON_EN to let CPU reads of the key-on registers also key on a channel.
module k007232_pcm
    import k007232_pkg::*;
(
    input  logic                CLK,
    input  logic                RES,
    input  logic                NRCS,
    input  logic                DACS,
    input  logic                NRD,
    input  logic [3:0]          AB,
    output logic                NO,
    output logic                NE,
    inout  wire  [7:0]          DB,
    input  logic [7:0]          RAM,
    output logic [SA_W-1:0]     SA,
    output logic [SAMPLE_W-1:0] ASD,
    output logic [SAMPLE_W-1:0] BSD,
    output logic                CK2M,
    output logic                SOEV
);

    phase_t          phase;
    logic            dacs_q;
    logic [3:0]      idx;
    logic            wr_stb;
    logic            wr_a;
    logic            wr_b;
    logic [3:0]      wr_sel_b;
    logic            loop_a;
    logic            loop_b;
    logic            keyon_a;
    logic            keyon_b;
    logic            rd_keyon_a;
    logic            rd_keyon_b;
    logic [SA_W-1:0] addr_a;
    logic [SA_W-1:0] addr_b;

    assign idx      = AB ^ 4'b0001;
    assign wr_stb   = dacs_q & ~DACS;
    assign wr_a     = wr_stb && (idx < REG_KEYON);
    assign wr_b     = wr_stb && (idx >= REG_CH_B) && (idx < REG_CH_B + REG_KEYON);
    assign wr_sel_b = idx - REG_CH_B;
    assign keyon_a  = (wr_stb && (idx == REG_KEYON)) || rd_keyon_a;
    assign keyon_b  = (wr_stb && (idx == REG_CH_B + REG_KEYON)) || rd_keyon_b;

`ifdef K007232_READ_KEYON_EN
    logic rd_act;
    logic rd_q;
    logic rd_start;

    assign rd_act     = !NRCS && !NRD;
    assign rd_start   = rd_act && !rd_q;
    assign rd_keyon_a = rd_start && (idx == REG_KEYON);
    assign rd_keyon_b = rd_start && (idx == REG_CH_B + REG_KEYON);

    always_ff @(posedge CLK) begin
        if (RES) rd_q <= 1'b0;
        else     rd_q <= rd_act;
    end
`else
    assign rd_keyon_a = 1'b0;
    assign rd_keyon_b = 1'b0;
`endif

    assign DB   = (!NRCS && !NRD) ? RAM : 'z;
    assign CK2M = (phase == PH_B);
    assign SA   = (phase == PH_A) ? addr_a : addr_b;

    // NE/NO are registered from the phase being left so they read inactive while in reset.
    always_ff @(posedge CLK) begin
        if (RES) begin
            phase  <= PH_A;
            dacs_q <= 1'b1;
            SOEV   <= 1'b0;
            loop_a <= 1'b0;
            loop_b <= 1'b0;
            NE     <= 1'b1;
            NO     <= 1'b1;
        end else begin
            phase  <= (phase == PH_A) ? PH_B : PH_A;
            NE     <= (phase == PH_A);
            NO     <= (phase == PH_B);
            dacs_q <= DACS;
            SOEV   <= wr_stb && (idx == REG_SOEV);
            if (wr_stb && (idx == REG_LOOP)) begin
                loop_a <= DB[0];
                loop_b <= DB[1];
            end
        end
    end

    k007232_channel u_ch_a (
        .clk     (CLK),
        .res     (RES),
        .wr_en   (wr_a),
        .wr_sel  (idx),
        .wr_data (DB),
        .keyon   (keyon_a),
        .loop_en (loop_a),
        .tick    (phase == PH_A),
        .ram     (RAM),
        .addr    (addr_a),
        .sample  (ASD)
    );

    k007232_channel u_ch_b (
        .clk     (CLK),
        .res     (RES),
        .wr_en   (wr_b),
        .wr_sel  (wr_sel_b),
        .wr_data (DB),
        .keyon   (keyon_b),
        .loop_en (loop_b),
        .tick    (phase == PH_B),
        .ram     (RAM),
        .addr    (addr_b),
        .sample  (BSD)
    );

endmodule

// File: tb/tb_k007232_pcm.sv
// Directed bench for k007232_pcm with a behavioural sample ROM on SA/RAM.
module tb_k007232_pcm;

    logic        clk = 1'b0;
    logic        res;
    logic        nrcs;
    logic        dacs;
    logic        nrd;
    logic [3:0]  ab;
    wire  [7:0]  db;
    logic [7:0]  db_drv;
    logic        db_oe;
    logic [7:0]  ram;
    logic [16:0] sa;
    logic [6:0]  asd;
    logic [6:0]  bsd;
    logic        ne_n;
    logic        no_n;
    logic        ck2m;
    logic        soev;

    int checks = 0;
    int errors = 0;

    logic [6:0] seq_a [9] = '{7'h01, 7'h23, 7'h45, 7'h67, 7'h76, 7'h54, 7'h32, 7'h10, 7'h00};
    logic [6:0] seq_b [3] = '{7'h23, 7'h7D, 7'h3A};

    always #5 clk = ~clk;

    assign db = db_oe ? db_drv : 'z;

    function automatic logic [7:0] rom(input logic [16:0] a);
        case (a)
            17'h00000: return 8'h01;
            17'h00001: return 8'h23;
            17'h00002: return 8'h45;
            17'h00003: return 8'h67;
            17'h00004: return 8'h76;
            17'h00005: return 8'h54;
            17'h00006: return 8'h32;
            17'h00007: return 8'h10;
            17'h00008: return 8'h00;
            17'h0000C: return 8'h23;
            17'h0000D: return 8'h7D;
            17'h0000E: return 8'h3A;
            17'h0000F: return 8'h94;
            17'h1FFFF: return 8'h11;
            default:   return 8'hFF;
        endcase
    endfunction

    always_comb ram = rom(sa);

    k007232_pcm dut (
        .CLK  (clk),
        .RES  (res),
        .NRCS (nrcs),
        .DACS (dacs),
        .NRD  (nrd),
        .AB   (ab),
        .NO   (no_n),
        .NE   (ne_n),
        .DB   (db),
        .RAM  (ram),
        .SA   (sa),
        .ASD  (asd),
        .BSD  (bsd),
        .CK2M (ck2m),
        .SOEV (soev)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called at a falling edge; holds DACS low for exactly one clock.
    task automatic wr(input logic [3:0] ridx, input logic [7:0] d);
        ab     = ridx ^ 4'b0001;
        db_drv = d;
        db_oe  = 1'b1;
        dacs   = 1'b0;
        @(negedge clk);
        dacs   = 1'b1;
        db_oe  = 1'b0;
        @(negedge clk);
    endtask

    task automatic align(input logic want);
        for (int i = 0; i < 3 && ck2m !== want; i++) @(negedge clk);
        chk("align", ck2m, want);
    endtask

    task automatic reset_dut();
        res = 1'b1;
        repeat (2) @(negedge clk);
        res = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        res = 1'b1; nrcs = 1'b1; nrd = 1'b1; dacs = 1'b1;
        ab = 4'h0; db_drv = 8'h00; db_oe = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_asd", asd, 0);
        chk("rst_bsd", bsd, 0);
        chk("rst_sa", sa, 0);
        chk("rst_soev", soev, 0);
        chk("rst_ne", ne_n, 1);
        chk("rst_no", no_n, 1);
        chk("rst_ck2m", ck2m, 0);
        res = 1'b0;

        @(negedge clk);
        chk("phb_ck2m", ck2m, 1);
        chk("phb_ne", ne_n, 1);
        chk("phb_no", no_n, 0);
        @(negedge clk);
        chk("pha_ck2m", ck2m, 0);
        chk("pha_ne", ne_n, 0);
        chk("pha_no", no_n, 1);

        // SOEV pulse from register 12
        ab = 4'b1101; dacs = 1'b0;
        @(negedge clk);
        chk("soev_hi", soev, 1);
        dacs = 1'b1;
        @(negedge clk);
        chk("soev_lo", soev, 0);
        @(negedge clk);
        chk("soev_lo2", soev, 0);

        // CPU read of the key-on index returns ROM data
        ab = 4'b0100; nrcs = 1'b0; nrd = 1'b0;
        #1;
        chk("db_read", db, 8'h01);
        repeat (2) @(negedge clk);
        nrcs = 1'b1; nrd = 1'b1;
        repeat (4) @(negedge clk);
`ifdef K007232_READ_KEYON_EN
        chk("read_keyon", asd, 7'h01);
`else
        chk("read_nokeyon", asd, 7'h00);
`endif

        // Channel A, 12-bit count from 0xFF8, looping
        reset_dut();
        wr(4'd0, 8'hF8); wr(4'd1, 8'h0F);
        wr(4'd2, 8'h00); wr(4'd3, 8'h00); wr(4'd4, 8'h00);
        wr(4'd13, 8'h01);
        align(1'b1);
        wr(4'd5, 8'h00);
        for (int t = 1; t <= 81; t++) begin
            logic [6:0] e;
            if (t <= 72)      e = seq_a[(t - 1) / 8];
            else if (t == 73) e = 7'h00;
            else              e = seq_a[(t - 74) / 8];
            chk($sformatf("asd_loop_t%0d", t), asd, e);
            repeat (2) @(negedge clk);
        end

        // Channel B, 8-bit count from 0xFC, no loop: stops on marker
        reset_dut();
        wr(4'd6, 8'hFC); wr(4'd7, 8'h10);
        wr(4'd8, 8'h0C); wr(4'd9, 8'h00); wr(4'd10, 8'h00);
        wr(4'd13, 8'h00);
        align(1'b0);
        wr(4'd11, 8'h00);
        for (int t = 1; t <= 16; t++) begin
            logic [6:0] e;
            e = (t <= 12) ? seq_b[(t - 1) / 4] : 7'h3A;
            chk($sformatf("bsd_stop_t%0d", t), bsd, e);
            repeat (2) @(negedge clk);
        end
        chk("stop_sa_pha", sa, 17'h00000);
        @(negedge clk);
        chk("stop_sa_phb", sa, 17'h0000F);
        chk("stop_no", no_n, 0);
        chk("stop_ne", ne_n, 1);
        chk("stop_asd_idle", asd, 0);

        // Mid-operation reset
        res = 1'b1;
        @(negedge clk);
        chk("mid_rst_bsd", bsd, 0);
        chk("mid_rst_sa", sa, 0);
        chk("mid_rst_ne", ne_n, 1);
        chk("mid_rst_no", no_n, 1);
        chk("mid_rst_ck2m", ck2m, 0);
        res = 1'b0;

        // Channel A, 4-bit prescaler from 0xFF8, then key-on restart mid-play
        reset_dut();
        wr(4'd0, 8'hF8); wr(4'd1, 8'h2F);
        wr(4'd2, 8'h00); wr(4'd3, 8'h00); wr(4'd4, 8'h00);
        wr(4'd13, 8'h01);
        align(1'b1);
        wr(4'd5, 8'h00);
        for (int t = 1; t <= 20; t++) begin
            chk($sformatf("asd_p4_t%0d", t), asd, seq_a[(t - 1) / 8]);
            repeat (2) @(negedge clk);
        end
        @(negedge clk);
        chk("p4_sa_before", sa, 17'h00002);
        wr(4'd5, 8'h00);
        chk("rekey_sa", sa, 17'h00000);
        chk("rekey_hold", asd, 7'h45);
        @(negedge clk);
        chk("rekey_first", asd, 7'h01);

        // Address wrap from 0x1FFFF
        reset_dut();
        wr(4'd0, 8'hFF); wr(4'd1, 8'h0F);
        wr(4'd2, 8'hFF); wr(4'd3, 8'hFF); wr(4'd4, 8'h01);
        align(1'b1);
        wr(4'd5, 8'h00);
        chk("wrap_top_byte", asd, 7'h11);
        @(negedge clk);
        chk("wrap_sa", sa, 17'h00000);
        @(negedge clk);
        chk("wrap_next_byte", asd, 7'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
